uart_byte_rx: RTL and testbench

//  UART byte receiver, 8N1, LSB first. Companion to Uart_byte_tx; same baud_set encoding.

---
 rtl/uart_byte_rx.sv | 165 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// Purpose : 8N1 UART byte receiver, LSB first; samples each bit at its centre.
// Latency : rx_done one cycle after the stop-bit centre sample (~9.5*BIT + 3 cycles from the line falling edge).
// Backpr. : none; the serial line cannot be stalled, so each strobe is a single cycle and must be taken when seen.
//
// Ports:
//   sys_clk    - system clock (single domain)
//   sys_rst    - asynchronous reset, active low
//   baud_set   - 0:9600 1:19200 2:38400 3:57600 4..7:115200, latched at each start edge
//   uart_rx    - asynchronous serial input, idle high
//   data_byte  - last correctly framed byte
//   rx_done    - one-cycle strobe, data_byte updated this cycle
//   frame_err  - one-cycle strobe, stop bit sampled low
//   uart_state - high while a frame (or a line break) is in progress
module uart_byte_rx #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       uart_state
);

  // Counter is sized for the slowest rate.
  localparam int CW = $clog2(CLK_FREQ / 9600 + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  function automatic logic [CW-1:0] bit_period(input logic [2:0] bs);
    case (bs)
      3'd0:    bit_period = CW'(CLK_FREQ / 9600);
      3'd1:    bit_period = CW'(CLK_FREQ / 19200);
      3'd2:    bit_period = CW'(CLK_FREQ / 38400);
      3'd3:    bit_period = CW'(CLK_FREQ / 57600);
      default: bit_period = CW'(CLK_FREQ / 115200);
    endcase
  endfunction

  logic          rx_meta;
  logic          rx_s;
  logic          rx_s_d;
  logic [2:0]    sync_vld;
  logic [2:0]    state;
  logic [CW-1:0] bit_len;
  logic [CW-1:0] div_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  logic [CW-1:0] bit_m1;
  logic [CW-1:0] half_m1;
  logic          start_edge;

  assign bit_m1  = bit_len - CW'(1);
  assign half_m1 = (bit_len >> 1) - CW'(1);

  // The synchroniser flops come out of reset high, so for the first three
  // cycles rx_s/rx_s_d reflect reset values rather than the pin. sync_vld
  // masks that window: a line that is already low when reset releases
  // (e.g. mid-frame) must not be mistaken for a fresh start edge.
  assign start_edge = sync_vld[2] & rx_s_d & ~rx_s;

  assign uart_state = (state != S_IDLE);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      rx_s_d    <= 1'b1;
      sync_vld  <= 3'b000;
      state     <= S_IDLE;
      bit_len   <= '0;
      div_cnt   <= '0;
      bit_idx   <= 3'd0;
      shreg     <= 8'h00;
      data_byte <= 8'h00;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= uart_rx;
      rx_s      <= rx_meta;
      rx_s_d    <= rx_s;
      sync_vld  <= {sync_vld[1:0], 1'b1};
      rx_done   <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (start_edge) begin
            bit_len <= bit_period(baud_set);
            div_cnt <= '0;
            state   <= S_START;
          end
        end

        // Half a bit in, confirm the start bit is still low; otherwise it
        // was a glitch and we quietly return to idle.
        S_START: begin
          if (div_cnt == half_m1) begin
            div_cnt <= '0;
            if (!rx_s) begin
              bit_idx <= 3'd0;
              state   <= S_DATA;
            end else begin
              state   <= S_IDLE;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        // From the start-bit centre, every full bit period lands on the
        // next bit centre.
        S_DATA: begin
          if (div_cnt == bit_m1) begin
            div_cnt        <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        // Leaving at the stop-bit centre gives half a bit of slack before a
        // back-to-back start edge can arrive.
        S_STOP: begin
          if (div_cnt == bit_m1) begin
            div_cnt <= '0;
            if (rx_s) begin
              data_byte <= shreg;
              rx_done   <= 1'b1;
              state     <= S_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= S_BRK;
            end
          end else begin
            div_cnt <= div_cnt + CW'(1);
          end
        end

        // Line break: wait for the line to go idle so a held-low line
        // produces only the one frame_err.
        S_BRK: begin
          if (rx_s) begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Purpose : self-checking bench for uart_byte_rx using randomised frames and a byte scoreboard.
// Latency : n/a (bench).
// Backpr. : n/a (bench).
module tb_uart_byte_rx;

  localparam int CLK_FREQ = 20_000_000;

  logic       sys_clk  = 1'b0;
  logic       sys_rst  = 1'b0;
  logic [2:0] baud_set = 3'd4;
  logic       uart_rx  = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done;
  logic       frame_err;
  logic       uart_state;

  uart_byte_rx #(.CLK_FREQ(CLK_FREQ)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .baud_set   (baud_set),
    .uart_rx    (uart_rx),
    .data_byte  (data_byte),
    .rx_done    (rx_done),
    .frame_err  (frame_err),
    .uart_state (uart_state)
  );

  always #5 sys_clk = ~sys_clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge sys_clk) cyc++;

  // Scoreboard: bytes the model expects vs bytes the DUT delivered.
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] last_good = 8'h00;
  int fe_cnt    = 0;
  int both_cnt  = 0;
  int done_cyc  = 0;
  int drive_cyc = 0;
  int start_cyc = 0;

  always @(negedge sys_clk) begin
    if (rx_done) begin
      got_q.push_back(data_byte);
      done_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (rx_done && frame_err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic int bit_of(input logic [2:0] bs);
    case (bs)
      3'd0:    return CLK_FREQ / 9600;
      3'd1:    return CLK_FREQ / 19200;
      3'd2:    return CLK_FREQ / 38400;
      3'd3:    return CLK_FREQ / 57600;
      default: return CLK_FREQ / 115200;
    endcase
  endfunction

  task automatic drive_bit(input logic v, input int n);
    @(posedge sys_clk);
    #1 uart_rx = v;
    drive_cyc = cyc;
    repeat (n - 1) @(posedge sys_clk);
  endtask

  // One 8N1 frame; baud_set is scrambled after the start bit to show it is
  // ignored mid-frame. Only frames with a good stop bit are expected.
  task automatic send(input logic [7:0] b, input logic [2:0] bs, input logic stop);
    int n;
    n = bit_of(bs);
    baud_set = bs;
    drive_bit(1'b0, n);
    start_cyc = drive_cyc;
    baud_set = 3'($urandom_range(0, 7));
    for (int i = 0; i < 8; i++) drive_bit(b[i], n);
    drive_bit(stop, n);
    if (stop) exp_q.push_back(b);
  endtask

  task automatic check_q(input string tag);
    chk({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_dat"}, 32'(got_q[i]), 32'(exp_q[i]));
    if (exp_q.size() > 0) last_good = exp_q[exp_q.size() - 1];
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n4;
    int half4;
    int fe0;
    n4    = bit_of(3'd4);
    half4 = n4 / 2;

    // Reset state
    repeat (5) @(posedge sys_clk);
    #1;
    chk("rst_data",  32'(data_byte),  32'h0);
    chk("rst_done",  32'(rx_done),    32'h0);
    chk("rst_ferr",  32'(frame_err),  32'h0);
    chk("rst_state", 32'(uart_state), 32'h0);
    sys_rst = 1'b1;
    repeat (10) @(posedge sys_clk);

    // Single frame at 115200
    send(8'hAA, 3'd4, 1'b1);
    check_q("aa");
    chk("aa_state", 32'(uart_state), 32'h0);
    chk("aa_ferr",  32'(fe_cnt),     32'h0);

    // Back-to-back frames, only one stop bit between them
    send(8'h55, 3'd4, 1'b1);
    send(8'hC3, 3'd4, 1'b1);
    check_q("b2b");

    // Slowest rate, with exact centre-of-stop latency
    send(8'h3C, 3'd0, 1'b1);
    check_q("slow");
    chk("slow_lat", 32'(done_cyc - start_cyc),
        32'(9 * bit_of(3'd0) + bit_of(3'd0) / 2 + 3));

    // Random bytes at random rates
    for (int k = 0; k < 4; k++)
      send(8'($urandom), 3'($urandom_range(3, 7)), 1'b1);
    check_q("rnd");
    chk("rnd_ferr", 32'(fe_cnt), 32'h0);

    // Glitch shorter than half a bit
    baud_set = 3'd4;
    repeat (20) @(posedge sys_clk);
    @(posedge sys_clk);
    #1 uart_rx = 1'b0;
    repeat (10) @(posedge sys_clk);
    #1 chk("gl_busy", 32'(uart_state), 32'h1);
    repeat (half4 / 2 - 10) @(posedge sys_clk);
    #1 uart_rx = 1'b1;
    repeat (half4 + 3 - half4 / 2) @(posedge sys_clk);
    #1 chk("gl_idle", 32'(uart_state), 32'h0);
    chk("gl_done", 32'(got_q.size()), 32'h0);
    chk("gl_ferr", 32'(fe_cnt), 32'h0);
    repeat (20) @(posedge sys_clk);

    // Bad stop bit followed by a long break
    fe0 = fe_cnt;
    send(8'hF0, 3'd4, 1'b0);
    repeat (20 * n4) @(posedge sys_clk);
    #1;
    chk("brk_ferr",  32'(fe_cnt - fe0), 32'h1);
    chk("brk_done",  32'(got_q.size()), 32'h0);
    chk("brk_data",  32'(data_byte),    32'(last_good));
    chk("brk_state", 32'(uart_state),   32'h1);
    uart_rx = 1'b1;
    repeat (6) @(posedge sys_clk);
    #1 chk("brk_rel", 32'(uart_state), 32'h0);
    repeat (n4) @(posedge sys_clk);

    // Reset during bit 4 of 8'h81, then a clean 8'h7E
    baud_set = 3'd4;
    drive_bit(1'b0, n4);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h81 >> i), n4);
    @(posedge sys_clk);
    #1 uart_rx = 1'b0;
    repeat (n4 / 3) @(posedge sys_clk);
    #1 chk("mr_busy", 32'(uart_state), 32'h1);
    sys_rst = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("mr_data",  32'(data_byte),  32'h0);
    chk("mr_done",  32'(rx_done),    32'h0);
    chk("mr_ferr",  32'(frame_err),  32'h0);
    chk("mr_state", 32'(uart_state), 32'h0);
    sys_rst = 1'b1;
    repeat (n4 - n4 / 3 - 4) @(posedge sys_clk);
    for (int i = 5; i < 8; i++) drive_bit(1'(8'h81 >> i), n4);
    drive_bit(1'b1, n4);
    send(8'h7E, 3'd4, 1'b1);
    check_q("mr");
    chk("mr_noerr", 32'(fe_cnt - fe0), 32'h1);

    chk("excl", 32'(both_cnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
